// File: rtl/lfsr_ks_arbiter.sv
// lfsr_ks_arbiter: controls an external Galois LFSR to produce keystream
// bytes. Two requesters share the stream through a round-robin arbiter. Each
// seed load is followed by a warm-up period whose bits are discarded.
//
// Handshake: ks_valid rises in HOLD with ks_byte/ks_id stable. It stays high
// until a cycle with ks_valid && ks_ready, which is the transfer. Only start
// or rst can withdraw the byte earlier.
module lfsr_ks_arbiter #(
  parameter int N      = 48,
  parameter int WARMUP = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] seed_i,
  input  logic [N-1:0] taps_i,
  input  logic [1:0]   req,
  output logic [7:0]   ks_byte,
  output logic         ks_valid,
  output logic         ks_id,
  input  logic         ks_ready,
  output logic         ks_rdy_o,
  output logic         busy,
  output logic [15:0]  byte_cnt,
  output logic         lfsr_ld,
  output logic         lfsr_en,
  output logic [N-1:0] lfsr_seed,
  output logic [N-1:0] lfsr_taps,
  input  logic         lfsr_k,
  output logic [2:0]   fsm_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WARM = 3'd2,
    ARB  = 3'd3,
    GEN  = 3'd4,
    HOLD = 3'd5
  } state_t;

  localparam logic [15:0] WARM_LAST = 16'(WARMUP - 1);

  state_t      state;
  logic        rr;
  logic        grant_id;
  logic [15:0] warm_cnt;
  logic [2:0]  bit_cnt;

  assign fsm_state = state;

  // Arbitration: a lone requester wins outright; a tie goes to the rr pointer.
  always_comb begin
    grant_id = req[1];
    if (req == 2'b11) grant_id = rr;
  end

  // Control FSM. Every output is a register set on the transition into its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ks_byte   <= 8'd0;
      ks_valid  <= 1'b0;
      ks_id     <= 1'b0;
      ks_rdy_o  <= 1'b0;
      busy      <= 1'b0;
      byte_cnt  <= 16'd0;
      lfsr_ld   <= 1'b0;
      lfsr_en   <= 1'b0;
      lfsr_seed <= '0;
      lfsr_taps <= '0;
      rr        <= 1'b0;
      warm_cnt  <= 16'd0;
      bit_cnt   <= 3'd0;
    end else if (start) begin
      // start wins from any state. A same-cycle HOLD transfer is absorbed
      // because byte_cnt is cleared here anyway.
      state     <= LOAD;
      lfsr_seed <= seed_i;
      lfsr_taps <= taps_i;
      byte_cnt  <= 16'd0;
      rr        <= 1'b0;
      ks_valid  <= 1'b0;
      ks_rdy_o  <= 1'b0;
      busy      <= 1'b1;
      lfsr_ld   <= 1'b1;
      lfsr_en   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          lfsr_ld <= 1'b0;
          lfsr_en <= 1'b0;
        end
        LOAD: begin
          state    <= WARM;
          warm_cnt <= 16'd0;
          lfsr_ld  <= 1'b0;
          lfsr_en  <= 1'b1;
        end
        WARM: begin
          if (warm_cnt == WARM_LAST) begin
            state    <= ARB;
            lfsr_en  <= 1'b0;
            ks_rdy_o <= 1'b1;
          end else begin
            warm_cnt <= warm_cnt + 16'd1;
          end
        end
        ARB: begin
          if (req != 2'b00) begin
            state   <= GEN;
            ks_id   <= grant_id;
            bit_cnt <= 3'd0;
            lfsr_en <= 1'b1;
          end
        end
        GEN: begin
          // lfsr_k is reg[0] before this edge's shift, so bits arrive LSB first.
          ks_byte[bit_cnt] <= lfsr_k;
          bit_cnt          <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state    <= HOLD;
            lfsr_en  <= 1'b0;
            ks_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (ks_ready) begin
            state    <= ARB;
            ks_valid <= 1'b0;
            byte_cnt <= byte_cnt + 16'd1;
            rr       <= ~ks_id;
          end
        end
        default: begin
          state    <= IDLE;
          lfsr_ld  <= 1'b0;
          lfsr_en  <= 1'b0;
          ks_valid <= 1'b0;
          ks_rdy_o <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_ks_arbiter.sv
// Bench for lfsr_ks_arbiter with N=48, WARMUP=8 and a behavioural Galois LFSR.
// Expected bytes are hand-derived. With taps=0 the LFSR is a plain right
// shift: warm-up drops the low seed byte, and each keystream byte is the
// next seed byte up.
module tb_lfsr_ks_arbiter;

  localparam int N = 48;
  localparam int WARMUP = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] seed_i = '0;
  logic [N-1:0] taps_i = '0;
  logic [1:0]   req = 2'b00;
  logic [7:0]   ks_byte;
  logic         ks_valid;
  logic         ks_id;
  logic         ks_ready = 1'b0;
  logic         ks_rdy_o;
  logic         busy;
  logic [15:0]  byte_cnt;
  logic         lfsr_ld;
  logic         lfsr_en;
  logic [N-1:0] lfsr_seed;
  logic [N-1:0] lfsr_taps;
  logic         lfsr_k;
  logic [2:0]   fsm_state;

  int total = 0;
  int bad = 0;

  lfsr_ks_arbiter #(.N(N), .WARMUP(WARMUP)) dut (
    .clk(clk), .rst(rst), .start(start), .seed_i(seed_i), .taps_i(taps_i),
    .req(req), .ks_byte(ks_byte), .ks_valid(ks_valid), .ks_id(ks_id),
    .ks_ready(ks_ready), .ks_rdy_o(ks_rdy_o), .busy(busy), .byte_cnt(byte_cnt),
    .lfsr_ld(lfsr_ld), .lfsr_en(lfsr_en), .lfsr_seed(lfsr_seed),
    .lfsr_taps(lfsr_taps), .lfsr_k(lfsr_k), .fsm_state(fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Bench LFSR: load on ld, Galois right shift on en, k is reg[0].
  logic [N-1:0] lreg = '0;
  always @(posedge clk) begin
    if (lfsr_ld) lreg <= lfsr_seed;
    else if (lfsr_en) lreg <= (lreg >> 1) ^ (lreg[0] ? lfsr_taps : '0);
  end
  assign lfsr_k = lreg[0];

  // ld/en mutual exclusion, checked every cycle
  always @(negedge clk) begin
    total++;
    if (lfsr_ld && lfsr_en) begin
      bad++;
      $display("FAIL ld_en_excl: ld=%b en=%b required not both 1", lfsr_ld, lfsr_en);
    end
  end

  // Pulse start with seed/taps and advance to the first ARB cycle (t+10).
  task automatic start_seq(input logic [N-1:0] s, input logic [N-1:0] t);
    @(negedge clk);
    start = 1'b1; seed_i = s; taps_i = t;
    @(negedge clk);
    start = 1'b0;
    repeat (WARMUP + 1) @(negedge clk);
  endtask

  // Advance to the first negedge with ks_valid=1, or fail after 30 cycles.
  task automatic wait_valid(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ks_valid) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout: ks_valid=0 after 30 cycles required 1", tag);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({ks_valid, ks_byte, ks_id, lfsr_ld, lfsr_en, byte_cnt, ks_rdy_o, busy, fsm_state} !== 32'd0
        || lfsr_seed !== '0 || lfsr_taps !== '0) begin
      bad++;
      $display("FAIL reset_vals: v=%b b=%h id=%b ld=%b en=%b cnt=%h rdy=%b busy=%b st=%0d required all 0",
               ks_valid, ks_byte, ks_id, lfsr_ld, lfsr_en, byte_cnt, ks_rdy_o, busy, fsm_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_start_latency;
    @(negedge clk);
    start = 1'b1; seed_i = 48'h0000_0000_FF00; taps_i = '0;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (lfsr_ld !== 1'b1 || lfsr_en !== 1'b0 || busy !== 1'b1 || lfsr_seed !== 48'h0000_0000_FF00) begin
      bad++;
      $display("FAIL load_cycle: ld=%b en=%b busy=%b seed=%h required ld=1 en=0 busy=1 seed=ff00",
               lfsr_ld, lfsr_en, busy, lfsr_seed);
    end
    for (int i = 0; i < WARMUP; i++) begin
      @(negedge clk);
      total++;
      if (lfsr_en !== 1'b1 || lfsr_ld !== 1'b0 || ks_rdy_o !== 1'b0) begin
        bad++;
        $display("FAIL warm_cycle%0d: en=%b ld=%b rdy=%b required en=1 ld=0 rdy=0", i, lfsr_en, lfsr_ld, ks_rdy_o);
      end
    end
    @(negedge clk);
    total++;
    if (ks_rdy_o !== 1'b1 || lfsr_en !== 1'b0) begin
      bad++;
      $display("FAIL rdy_at_t10: rdy=%b en=%b required rdy=1 en=0", ks_rdy_o, lfsr_en);
    end
  endtask

  // Continues from the FF00 warm-up: the first byte is FF, then 00.
  task automatic test_single_req;
    logic [7:0] exp_b[2];
    exp_b[0] = 8'hFF; exp_b[1] = 8'h00;
    ks_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req = 2'b01;
      repeat (8) @(negedge clk);
      total++;
      if (ks_valid !== 1'b0) begin
        bad++;
        $display("FAIL early_valid%0d: ks_valid=%b at a+8 required 0", k, ks_valid);
      end
      @(negedge clk);
      total++;
      if (ks_valid !== 1'b1 || ks_byte !== exp_b[k] || ks_id !== 1'b0) begin
        bad++;
        $display("FAIL single_byte%0d: v=%b byte=%h id=%b required v=1 byte=%h id=0",
                 k, ks_valid, ks_byte, ks_id, exp_b[k]);
      end
      req = 2'b00;
      @(negedge clk);
    end
    total++;
    if (byte_cnt !== 16'd2) begin
      bad++;
      $display("FAIL single_cnt: byte_cnt=%0d required 2", byte_cnt);
    end
    ks_ready = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [7:0] exp_b[4];
    exp_b[0] = 8'h9A; exp_b[1] = 8'h78; exp_b[2] = 8'h56; exp_b[3] = 8'h34;
    start_seq(48'h1234_5678_9ABC, '0);
    req = 2'b11; ks_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_valid("rr");
      total++;
      if (ks_id !== 1'(k % 2) || ks_byte !== exp_b[k]) begin
        bad++;
        $display("FAIL rr_grant%0d: id=%b byte=%h required id=%0d byte=%h", k, ks_id, ks_byte, k % 2, exp_b[k]);
      end
      @(negedge clk);
      total++;
      if (byte_cnt !== 16'(k + 1) || ks_valid !== 1'b0) begin
        bad++;
        $display("FAIL rr_cnt%0d: byte_cnt=%0d v=%b required %0d v=0", k, byte_cnt, ks_valid, k + 1);
      end
    end
    req = 2'b00; ks_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold_stall;
    start_seq(48'h1234_5678_9ABC, '0);
    req = 2'b10;
    @(negedge clk);
    req = 2'b00;
    wait_valid("stall");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (ks_valid !== 1'b1 || ks_byte !== 8'h9A || ks_id !== 1'b1 || lfsr_en !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable%0d: v=%b byte=%h id=%b en=%b required v=1 byte=9a id=1 en=0",
                 i, ks_valid, ks_byte, ks_id, lfsr_en);
      end
    end
    ks_ready = 1'b1;
    @(negedge clk);
    total++;
    if (ks_valid !== 1'b0 || byte_cnt !== 16'd1) begin
      bad++;
      $display("FAIL stall_release: v=%b cnt=%0d required v=0 cnt=1", ks_valid, byte_cnt);
    end
    ks_ready = 1'b0;
  endtask

  task automatic test_start_mid_gen;
    req = 2'b01;
    repeat (2) @(negedge clk);
    start = 1'b1; seed_i = 48'h0000_00C3_A500; taps_i = '0; req = 2'b00;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (ks_valid !== 1'b0 || lfsr_ld !== 1'b1 || byte_cnt !== 16'd0) begin
      bad++;
      $display("FAIL abort_gen: v=%b ld=%b cnt=%0d required v=0 ld=1 cnt=0", ks_valid, lfsr_ld, byte_cnt);
    end
    repeat (WARMUP + 1) @(negedge clk);
    req = 2'b11; ks_ready = 1'b1;
    wait_valid("restart");
    total++;
    if (ks_byte !== 8'hA5 || ks_id !== 1'b0) begin
      bad++;
      $display("FAIL restart_byte: byte=%h id=%b required byte=a5 id=0", ks_byte, ks_id);
    end
    req = 2'b00;
    @(negedge clk);
    ks_ready = 1'b0;
  endtask

  task automatic test_rst_hold;
    req = 2'b10;
    wait_valid("rsthold");
    total++;
    if (ks_byte !== 8'hC3 || ks_id !== 1'b1) begin
      bad++;
      $display("FAIL pre_rst_byte: byte=%h id=%b required byte=c3 id=1", ks_byte, ks_id);
    end
    rst = 1'b1; start = 1'b1; ks_ready = 1'b1; req = 2'b00;
    @(negedge clk);
    total++;
    if ({ks_valid, ks_byte, ks_id, lfsr_ld, lfsr_en, byte_cnt, ks_rdy_o, busy, fsm_state} !== 32'd0
        || lfsr_seed !== '0 || lfsr_taps !== '0) begin
      bad++;
      $display("FAIL rst_in_hold: v=%b b=%h id=%b ld=%b en=%b cnt=%h rdy=%b busy=%b st=%0d required all 0",
               ks_valid, ks_byte, ks_id, lfsr_ld, lfsr_en, byte_cnt, ks_rdy_o, busy, fsm_state);
    end
    rst = 1'b0; start = 1'b0; ks_ready = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || fsm_state !== 3'd0 || lfsr_ld !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_rst: busy=%b st=%0d ld=%b required 0 0 0", busy, fsm_state, lfsr_ld);
    end
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_single_req();
    test_round_robin();
    test_hold_stall();
    test_start_mid_gen();
    test_rst_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_ks_arbiter.md
LFSR_KS_ARBITER -- requirements
Module: lfsr_ks_arbiter

Interface
REQ-001 SHALL have parameter N, default 48: LFSR width.
REQ-002 SHALL have parameter WARMUP, default 64: keystream bits discarded after each seed load; legal range 1..65535.
REQ-003 SHALL have ports, one per line (name  direction  width  meaning):
- clk  in  1  clock; rising-edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  pulse; latch seed_i/taps_i and (re)initialise the keystream.
- seed_i  in  N  seed value.
- taps_i  in  N  Galois feedback taps.
- req  in  2  per-requester byte request; level, held until the byte is delivered.
- ks_byte  out  8  keystream byte.
- ks_valid  out  1  ks_byte valid.
- ks_id  out  1  requester that owns ks_byte.
- ks_ready  in  1  consumer accepts ks_byte.
- ks_rdy_o  out  1  high when warm-up is complete and the block is idle or serving.
- busy  out  1  high in every state except IDLE.
- byte_cnt  out  16  bytes delivered since the last start; wraps.
- lfsr_ld  out  1  to LFSR ld.
- lfsr_en  out  1  to LFSR en.
- lfsr_seed  out  N  to LFSR lfsr_i.
- lfsr_taps  out  N  to LFSR taps.
- lfsr_k  in  1  from LFSR k (current reg[0]).

Function
REQ-004 SHALL implement FSM states IDLE, LOAD, WARM, ARB, GEN and HOLD.
REQ-005 IDLE: all LFSR controls are low; start latches seed_i and taps_i into registers that drive lfsr_seed/lfsr_taps, then the FSM moves to LOAD.
REQ-006 LOAD: lfsr_ld=1 and lfsr_en=0 for exactly 1 cycle, then WARM with the warm counter cleared.
REQ-007 WARM: lfsr_en=1 for exactly WARMUP cycles, lfsr_k ignored, then ARB.
REQ-008 ARB: lfsr_en=0; ks_rdy_o=1; if req is 0 the FSM stays in ARB.
REQ-009 ARB, one requester: if exactly one req bit is set, that requester is granted and the FSM moves to GEN.
REQ-010 ARB, both requesters: if both req bits are set, the requester selected by the round-robin pointer rr is granted.
REQ-011 Grant: the granted id is latched into ks_id and the bit counter is cleared.
REQ-012 GEN: lfsr_en=1 for exactly 8 cycles; in cycle i (i=0..7) lfsr_k is sampled into ks_byte[i] (LSB first), then HOLD.
REQ-013 HOLD: ks_valid=1 and lfsr_en=0; ks_byte and ks_id are stable.
REQ-014 HOLD transfer: on ks_valid&&ks_ready, byte_cnt increments by 1 (16-bit wrap, 0xFFFF->0x0000), rr becomes the other id, and the FSM moves to ARB the next cycle.
REQ-015 ks_valid SHALL be high only in HOLD and SHALL NOT drop without ks_ready, except on start or rst.
REQ-016 lfsr_ld and lfsr_en SHALL never be high in the same cycle.
REQ-017 Latency: start sampled at cycle t gives lfsr_ld=1 at t+1, lfsr_en=1 over t+2..t+1+WARMUP, and ks_rdy_o=1 from t+2+WARMUP.
REQ-018 Grant latency: req seen in ARB at cycle a gives ks_valid=1 at a+9.
REQ-019 start in any non-IDLE state SHALL abort the current operation, relatch seed/taps, clear byte_cnt, reset rr to 0 and go to LOAD.
REQ-020 start in HOLD with ks_ready=1 SHALL count the transfer as completed before byte_cnt is cleared, i.e. byte_cnt=0 after the restart.
REQ-021 Requester req changes are sampled only in ARB; dropping req during GEN or HOLD does not cancel the byte.
REQ-022 busy=1 in LOAD, WARM, ARB, GEN and HOLD; busy=0 in IDLE.

Reset
REQ-023 rst SHALL force IDLE with these values: ks_valid=0, ks_byte=0, ks_id=0, lfsr_ld=0, lfsr_en=0, lfsr_seed=0, lfsr_taps=0, byte_cnt=0, rr=0, ks_rdy_o=0, busy=0.
REQ-024 rst SHALL override start and ks_ready in the same cycle.
REQ-025 rst mid-GEN or mid-HOLD SHALL discard the partial or held byte.

Verification
REQ-026 Setup for the scenarios below: N=48, WARMUP=8, bench LFSR instance connected.
REQ-027 Scenario: seed=48'hFF00, taps=0, start -> lfsr_ld at t+1, 8 en cycles, ks_rdy_o at t+10.
REQ-028 Scenario (continues REQ-027): req=01 with ks_ready tied high -> ks_byte=8'hFF, ks_id=0, ks_valid at a+9; second req=01 -> ks_byte=8'h00; byte_cnt=2.
REQ-029 Scenario: req=11 held, ks_ready=1 -> grants alternate 0,1,0,1; byte_cnt increments once per transfer.
REQ-030 Scenario: HOLD with ks_ready=0 for 20 cycles -> ks_valid, ks_byte and ks_id remain constant and lfsr_en=0 throughout.
REQ-031 Scenario: start asserted mid-GEN -> ks_valid stays 0, lfsr_ld=1 next cycle, byte_cnt=0; first byte after warm-up matches the new seed.
REQ-032 Scenario: rst asserted in HOLD -> all outputs take their REQ-023 values next cycle; lfsr_ld/lfsr_en mutual exclusion asserted in every cycle.
